// File: rtl/predictor_arbiter.sv
// Two-port branch predictor table (2-bit saturating counters) with a
// round-robin lookup arbiter and a 2-deep resolved-branch update FIFO.
module predictor_arbiter #(
    parameter int         IDX_W = 4,
    parameter logic [1:0] INIT  = 2'b01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [IDX_W-1:0] idx0,
    input  logic [IDX_W-1:0] idx1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             pred_valid0,
    output logic             pred_valid1,
    output logic             prediction0,
    output logic             prediction1,
    input  logic             result,
    input  logic [IDX_W-1:0] res_idx,
    input  logic             taken,
    output logic             upd_ready,
    output logic [7:0]       dropped
);
    localparam int ENTRIES = 1 << IDX_W;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_t;

    logic [1:0]            ctr [ENTRIES];
    upd_t                  fifo [2];
    logic [1:0]            count;
    logic                  rr;      // requester favoured on a tie
    logic [1:0]            req;
    logic [1:0]            gnt;
    logic [1:0][IDX_W-1:0] idx;
    logic [1:0]            pvld;
    logic [1:0]            pbit;
    logic                  push;
    logic                  drain;
    upd_t                  new_upd;

    assign req     = {req1, req0};
    assign idx     = {idx1, idx0};
    assign new_upd = '{idx: res_idx, taken: taken};

    function automatic logic [1:0] sat_upd(input logic [1:0] c, input logic t);
        if (t)
            return (c == 2'd3) ? c : c + 2'd1;
        else
            return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    // A full FIFO steals the cycle so updates always make forward progress.
    always_comb begin
        gnt = '0;
        if (!reset && count != 2'd2) begin
            if (req == 2'b11)
                gnt = rr ? 2'b10 : 2'b01;
            else
                gnt = req;
        end
    end

    assign gnt0        = gnt[0];
    assign gnt1        = gnt[1];
    assign upd_ready   = (count < 2'd2);
    assign push        = result && upd_ready;
    assign drain       = (count != 2'd0) && (gnt == 2'b00);
    assign pred_valid0 = pvld[0];
    assign pred_valid1 = pvld[1];
    assign prediction0 = pbit[0];
    assign prediction1 = pbit[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= INIT;
        end else if (drain) begin
            ctr[fifo[0].idx] <= sat_upd(ctr[fifo[0].idx], fifo[0].taken);
        end
    end

    // Push requires count<2 and pop requires count>0, so push+pop implies count==1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= 2'd0;
            fifo[0] <= '0;
            fifo[1] <= '0;
        end else begin
            case ({push, drain})
                2'b01: begin
                    fifo[0] <= fifo[1];
                    count   <= count - 2'd1;
                end
                2'b10: begin
                    fifo[count[0]] <= new_upd;
                    count          <= count + 2'd1;
                end
                2'b11: fifo[0] <= new_upd;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr      <= 1'b0;
            dropped <= 8'd0;
        end else begin
            if (gnt[0])
                rr <= 1'b1;
            else if (gnt[1])
                rr <= 1'b0;
            if (result && !upd_ready && dropped != 8'hff)
                dropped <= dropped + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pvld <= '0;
            pbit <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                pvld[p] <= gnt[p];
                if (gnt[p])
                    pbit[p] <= ctr[idx[p]][1];
            end
        end
    end

endmodule

// File: tb/tb_predictor_arbiter.sv
// Randomized and directed checks of predictor_arbiter against a queue-based
// reference model of the table, update FIFO and arbiter.
module tb_predictor_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, result, taken;
    logic [3:0] idx0, idx1, res_idx;
    logic       gnt0, gnt1, pred_valid0, pred_valid1, prediction0, prediction1;
    logic       upd_ready;
    logic [7:0] dropped;

    int vectors = 0;
    int errors  = 0;

    // reference model state
    int tbl [16];
    int q [$];
    int fav;
    int edrop;
    bit eg0, eg1, epv0, epv1, epr0, epr1;

    predictor_arbiter #(.IDX_W(4), .INIT(2'b01)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .idx0(idx0), .idx1(idx1),
        .gnt0(gnt0), .gnt1(gnt1),
        .pred_valid0(pred_valid0), .pred_valid1(pred_valid1),
        .prediction0(prediction0), .prediction1(prediction1),
        .result(result), .res_idx(res_idx), .taken(taken),
        .upd_ready(upd_ready), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) tbl[i] = 1;
        q.delete();
        fav = 0; edrop = 0;
        eg0 = 0; eg1 = 0; epv0 = 0; epv1 = 0; epr0 = 0; epr1 = 0;
    endtask

    // Apply inputs just after a rising edge, predict grants, settle to negedge.
    task automatic drive(input bit r0, input logic [3:0] i0, input bit r1, input logic [3:0] i1,
                         input bit res, input logic [3:0] ri, input bit tk);
        req0 = r0; idx0 = i0; req1 = r1; idx1 = i1;
        result = res; res_idx = ri; taken = tk;
        eg0 = 0; eg1 = 0;
        if (q.size() < 2) begin
            if (r0 && r1) begin
                if (fav == 0) eg0 = 1; else eg1 = 1;
            end else begin
                eg0 = r0; eg1 = r1;
            end
        end
        @(negedge clk);
    endtask

    // Advance the model through one rising edge and move the DUT with it.
    task automatic advance();
        int sz, e, i;
        sz = q.size();
        epv0 = eg0; epv1 = eg1;
        if (eg0) epr0 = (tbl[idx0] >= 2);
        if (eg1) epr1 = (tbl[idx1] >= 2);
        if (sz > 0 && !eg0 && !eg1) begin
            e = q.pop_front();
            i = e / 2;
            if (e % 2 == 1) tbl[i] = (tbl[i] == 3) ? 3 : tbl[i] + 1;
            else            tbl[i] = (tbl[i] == 0) ? 0 : tbl[i] - 1;
        end
        if (result) begin
            if (sz < 2) q.push_back(int'(res_idx) * 2 + int'(taken));
            else if (edrop < 255) edrop++;
        end
        if (eg0) fav = 1;
        else if (eg1) fav = 0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 0; req1 = 0; result = 0; idx0 = 0; idx1 = 0; res_idx = 0; taken = 0;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req0 = 1; req1 = 1; idx0 = 0; idx1 = 0; result = 0; res_idx = 0; taken = 0;
        model_reset();
        #1;
        vectors++; if ({gnt0, gnt1} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b%b exp 00", gnt0, gnt1); end
        vectors++; if ({pred_valid0, pred_valid1} !== 2'b00) begin errors++; $display("FAIL reset_pv got %b%b exp 00", pred_valid0, pred_valid1); end
        vectors++; if ({prediction0, prediction1} !== 2'b00) begin errors++; $display("FAIL reset_pred got %b%b exp 00", prediction0, prediction1); end
        vectors++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b exp 1", upd_ready); end
        vectors++; if (dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped got %0d exp 0", dropped); end
        @(negedge clk);
        reset = 1'b0; req0 = 0; req1 = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_lookup();
        drive(1, 4'd3, 0, 4'd0, 0, 4'd0, 0);
        vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL basic_gnt got %b%b exp 10", gnt0, gnt1); end
        advance();
        vectors++; if (pred_valid0 !== 1'b1 || prediction0 !== 1'b0) begin errors++; $display("FAIL basic_pred got v=%b p=%b exp v=1 p=0", pred_valid0, prediction0); end
        drive(0, 4'd0, 0, 4'd0, 0, 4'd0, 0);
        advance();
        vectors++; if (pred_valid0 !== 1'b0 || prediction0 !== 1'b0) begin errors++; $display("FAIL basic_hold got v=%b p=%b exp v=0 p=0", pred_valid0, prediction0); end
    endtask

    task automatic upd_burst(input int n, input bit tk);
        for (int k = 0; k < n; k++) begin drive(0, 0, 0, 0, 1, 4'd5, tk); advance(); end
        for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 0, 0, 0, 0); advance(); end
    endtask

    task automatic test_saturation();
        upd_burst(3, 1);
        drive(1, 4'd5, 0, 0, 0, 0, 0); advance();
        vectors++; if (prediction0 !== 1'b1 || prediction0 !== epr0) begin errors++; $display("FAIL sat_up3 got %b exp 1", prediction0); end
        upd_burst(5, 1);
        drive(0, 0, 1, 4'd5, 0, 0, 0); advance();
        vectors++; if (prediction1 !== 1'b1 || pred_valid1 !== 1'b1) begin errors++; $display("FAIL sat_top got v=%b p=%b exp v=1 p=1", pred_valid1, prediction1); end
        upd_burst(4, 0);
        drive(1, 4'd5, 0, 0, 0, 0, 0); advance();
        vectors++; if (prediction0 !== 1'b0) begin errors++; $display("FAIL sat_down got %b exp 0", prediction0); end
        // one step up from a floor of 0 must stay below the taken threshold
        upd_burst(1, 1);
        drive(1, 4'd5, 0, 0, 0, 0, 0); advance();
        vectors++; if (prediction0 !== 1'b0 || prediction0 !== epr0) begin errors++; $display("FAIL sat_floor got %b exp 0", prediction0); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 4'd1, 1, 4'd2, 0, 0, 0);
            vectors++;
            if (gnt0 !== ((k % 2) == 0) || gnt1 !== ((k % 2) == 1) || gnt0 !== eg0)
                begin errors++; $display("FAIL rr_gnt k=%0d got %b%b exp %b%b", k, gnt0, gnt1, eg0, eg1); end
            advance();
            vectors++;
            if (pred_valid0 !== epv0 || pred_valid1 !== epv1)
                begin errors++; $display("FAIL rr_pv k=%0d got %b%b exp %b%b", k, pred_valid0, pred_valid1, epv0, epv1); end
        end
    endtask

    task automatic test_fifo_full();
        int dut_forced, exp_forced;
        dut_forced = 0; exp_forced = 0;
        for (int k = 0; k < 10; k++) begin
            drive(1, 4'(k), 1, 4'(k + 3), 1, 4'(k + 7), k[0]);
            if (gnt0 === 1'b0 && gnt1 === 1'b0 && upd_ready === 1'b0) dut_forced++;
            if (!eg0 && !eg1 && q.size() == 2) exp_forced++;
            vectors++;
            if (gnt0 !== eg0 || gnt1 !== eg1 || upd_ready !== (q.size() < 2))
                begin errors++; $display("FAIL full_arb k=%0d got g=%b%b r=%b exp g=%b%b r=%b", k, gnt0, gnt1, upd_ready, eg0, eg1, q.size() < 2); end
            advance();
            vectors++;
            if (dropped !== 8'(edrop) || pred_valid0 !== epv0 || pred_valid1 !== epv1)
                begin errors++; $display("FAIL full_state k=%0d got d=%0d pv=%b%b exp d=%0d pv=%b%b", k, dropped, pred_valid0, pred_valid1, edrop, epv0, epv1); end
        end
        vectors++;
        if (dut_forced !== exp_forced) begin errors++; $display("FAIL full_forced got %0d exp %0d", dut_forced, exp_forced); end
    endtask

    task automatic test_dropped_sat();
        for (int k = 0; k < 600; k++) begin drive(1, 0, 1, 0, 1, 4'd4, 1); advance(); end
        vectors++;
        if (dropped !== 8'd255 || dropped !== 8'(edrop)) begin errors++; $display("FAIL drop_sat got %0d exp 255", dropped); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 500; k++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
                  1'($urandom_range(0, 2) != 0), 4'($urandom), 1'($urandom));
            vectors++;
            if (gnt0 !== eg0 || gnt1 !== eg1 || upd_ready !== (q.size() < 2))
                begin errors++; $display("FAIL rnd_arb k=%0d got g=%b%b r=%b exp g=%b%b r=%b", k, gnt0, gnt1, upd_ready, eg0, eg1, q.size() < 2); end
            advance();
            vectors++;
            if (pred_valid0 !== epv0 || pred_valid1 !== epv1 || prediction0 !== epr0 || prediction1 !== epr1 || dropped !== 8'(edrop))
                begin errors++; $display("FAIL rnd_out k=%0d got pv=%b%b p=%b%b d=%0d exp pv=%b%b p=%b%b d=%0d", k, pred_valid0, pred_valid1, prediction0, prediction1, dropped, epv0, epv1, epr0, epr1, edrop); end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 0, 1, 4'd2, 1); advance(); end
        for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 0, 0, 0, 0); advance(); end
        drive(1, 4'd9, 0, 0, 1, 4'd9, 1); advance();
        drive(1, 4'd9, 0, 0, 1, 4'd9, 1); advance();
        reset = 1'b1;
        model_reset();
        #1;
        vectors++;
        if (gnt0 !== 1'b0 || pred_valid0 !== 1'b0 || prediction0 !== 1'b0 || upd_ready !== 1'b1 || dropped !== 8'd0)
            begin errors++; $display("FAIL midreset got g=%b pv=%b p=%b r=%b d=%0d exp 0 0 0 1 0", gnt0, pred_valid0, prediction0, upd_ready, dropped); end
        @(negedge clk);
        reset = 1'b0; req0 = 0; result = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            drive(1, 4'(i), 0, 0, 0, 0, 0); advance();
            vectors++;
            if (pred_valid0 !== 1'b1 || prediction0 !== 1'b0)
                begin errors++; $display("FAIL midreset_tbl idx=%0d got v=%b p=%b exp v=1 p=0", i, pred_valid0, prediction0); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_lookup();
        test_saturation();
        test_round_robin();
        test_fifo_full();
        test_dropped_sat();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
